// File: rtl/uart_msg_sequencer_pkg.sv
// rtl/uart_msg_sequencer_pkg.sv - shared codes, state encodings and divider helper for the UART message sender
package uart_msg_sequencer_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    typedef enum logic [1:0] {
        MSG_IDLE,
        MSG_LOAD,
        MSG_SEND,
        MSG_FINISH
    } msg_state_t;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_t;

    function automatic int calc_div(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_tx_core.sv
// rtl/uart_tx_core.sv - single-frame transmitter: baud counter, LSB-first shifter, parity and stop bits
module uart_tx_core
    import uart_msg_sequencer_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int DIV       = 868,
    parameter int PARITY    = PARITY_NONE,
    parameter int STOP_BITS = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] data,
    output logic              ready,
    output logic              TXD
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    tx_state_t         state, state_next;
    logic [CW-1:0]     cnt;
    logic [3:0]        bit_cnt;
    logic [DATA_W-1:0] shreg;
    logic              par_bit;
    logic              tick, last_data, last_stop, txd_next;

    assign tick      = (cnt == CW'(DIV - 1));
    assign last_data = (bit_cnt == 4'(DATA_W - 1));
    assign last_stop = (bit_cnt == 4'(STOP_BITS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= TX_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            TX_IDLE:   if (load) state_next = TX_START;
            TX_START:  if (tick) state_next = TX_DATA;
            TX_DATA:   if (tick && last_data)
                           state_next = (PARITY != PARITY_NONE) ? TX_PARITY : TX_STOP;
            TX_PARITY: if (tick) state_next = TX_STOP;
            TX_STOP:   if (tick && last_stop) state_next = TX_IDLE;
            default:   state_next = TX_IDLE;
        endcase
    end

    // ready also covers the final stop tick so the next LOAD lands without an extra idle clock
    always_comb begin
        txd_next = 1'b1;
        ready    = 1'b0;
        case (state)
            TX_IDLE:   ready    = 1'b1;
            TX_START:  txd_next = 1'b0;
            TX_DATA:   txd_next = shreg[0];
            TX_PARITY: txd_next = par_bit;
            TX_STOP:   ready    = tick && last_stop;
            default:   txd_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            par_bit <= 1'b0;
            TXD     <= 1'b1;
        end else begin
            TXD <= txd_next;
            if (state == TX_IDLE || tick) cnt <= '0;
            else                          cnt <= cnt + 1'b1;
            if (state != state_next) bit_cnt <= '0;
            else if (tick)           bit_cnt <= bit_cnt + 1'b1;
            if (state == TX_IDLE && load) begin
                shreg   <= data;
                par_bit <= (^data) ^ (PARITY == PARITY_ODD);
            end else if (state == TX_DATA && tick) begin
                shreg <= shreg >> 1;
            end
        end
    end

endmodule

// File: rtl/uart_msg_sequencer.sv
// rtl/uart_msg_sequencer.sv - message buffer plus FSM that streams msg_len entries through uart_tx_core
module uart_msg_sequencer
    import uart_msg_sequencer_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 16,
    parameter int CLK_HZ    = 100000000,
    parameter int BAUD      = 115200,
    parameter int PARITY    = PARITY_NONE,
    parameter int STOP_BITS = 1,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic              CLK100MHZ,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [AW:0]       msg_len,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [AW-1:0]     byte_idx,
    output logic              TXD
);

    localparam int        DIV     = calc_div(CLK_HZ, BAUD);
    localparam logic [AW:0] DEPTH_L = (AW + 1)'(DEPTH);

    logic [DATA_W-1:0] buf_mem [DEPTH];
    logic [AW:0]       len_q;
    msg_state_t        state, state_next;
    logic              load, core_ready, last_entry;

    assign last_entry = ({1'b0, byte_idx} == len_q - 1'b1);

    // buffer is frozen while a message is in flight
    always_ff @(posedge CLK100MHZ) begin
        if (wr_en && !busy) buf_mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge CLK100MHZ or negedge reset_n) begin
        if (!reset_n) state <= MSG_IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            MSG_IDLE:   if (start) state_next = (msg_len == '0) ? MSG_FINISH : MSG_LOAD;
            MSG_LOAD:   state_next = MSG_SEND;
            MSG_SEND:   if (core_ready) state_next = last_entry ? MSG_FINISH : MSG_LOAD;
            MSG_FINISH: state_next = MSG_IDLE;
            default:    state_next = MSG_IDLE;
        endcase
    end

    always_comb begin
        load = (state == MSG_LOAD);
        busy = (state == MSG_LOAD) || (state == MSG_SEND);
        done = (state == MSG_FINISH);
    end

    always_ff @(posedge CLK100MHZ or negedge reset_n) begin
        if (!reset_n) begin
            len_q    <= '0;
            byte_idx <= '0;
        end else if (state == MSG_IDLE && start) begin
            len_q    <= (msg_len > DEPTH_L) ? DEPTH_L : msg_len;
            byte_idx <= '0;
        end else if (state == MSG_SEND && core_ready && !last_entry) begin
            byte_idx <= byte_idx + 1'b1;
        end
    end

    uart_tx_core #(
        .DATA_W   (DATA_W),
        .DIV      (DIV),
        .PARITY   (PARITY),
        .STOP_BITS(STOP_BITS)
    ) u_core (
        .clk  (CLK100MHZ),
        .rst_n(reset_n),
        .load (load),
        .data (buf_mem[byte_idx]),
        .ready(core_ready),
        .TXD  (TXD)
    );

endmodule

// File: tb/tb_uart_msg_sequencer.sv
// tb/tb_uart_msg_sequencer.sv - scoreboard bench: three parity/stop variants, frames decoded from TXD
module tb_uart_msg_sequencer;

    typedef struct {
        int         id;
        logic [7:0] data;
        logic       par;
        int         idx;
    } exp_t;

    logic       clk     = 1'b0;
    logic       reset_n = 1'b0;
    logic       wr_en_v    [3];
    logic       start_v    [3];
    logic       busy_v     [3];
    logic       done_v     [3];
    logic       txd_v      [3];
    logic [1:0] byte_idx_v [3];
    logic [1:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic [2:0] msg_len = '0;
    int         done_cnt [3] = '{0, 0, 0};
    exp_t       sb_q [$];
    int         n_cmp  = 0;
    int         n_fail = 0;
    time        last_rst = 0;
    logic [7:0] msg_a [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};

    always #5 clk = ~clk;
    always @(negedge reset_n) last_rst = $time;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int PAR_G  = (g == 1) ? 1 : ((g == 2) ? 2 : 0);
        localparam int STOP_G = (g == 1) ? 2 : 1;

        uart_msg_sequencer #(
            .DATA_W(8), .DEPTH(4), .CLK_HZ(1000), .BAUD(100),
            .PARITY(PAR_G), .STOP_BITS(STOP_G)
        ) dut (
            .CLK100MHZ(clk),
            .reset_n  (reset_n),
            .wr_en    (wr_en_v[g]),
            .wr_addr  (wr_addr),
            .wr_data  (wr_data),
            .msg_len  (msg_len),
            .start    (start_v[g]),
            .busy     (busy_v[g]),
            .done     (done_v[g]),
            .byte_idx (byte_idx_v[g]),
            .TXD      (txd_v[g])
        );

        always @(posedge clk) if (done_v[g]) done_cnt[g] <= done_cnt[g] + 1;

        // decode one frame per start bit, sampling mid-bit, then pop and compare
        always begin : mon
            logic [7:0] d;
            logic       p, st, stop_ok;
            int         idx_s;
            time        t0;
            exp_t       e;
            @(negedge txd_v[g]);
            t0 = $time;
            repeat (5) @(negedge clk);
            st    = txd_v[g];
            idx_s = int'(byte_idx_v[g]);
            for (int b = 0; b < 8; b++) begin
                repeat (10) @(negedge clk);
                d[b] = txd_v[g];
            end
            p = 1'b0;
            if (PAR_G != 0) begin
                repeat (10) @(negedge clk);
                p = txd_v[g];
            end
            stop_ok = 1'b1;
            for (int s = 0; s < STOP_G; s++) begin
                repeat (10) @(negedge clk);
                if (!txd_v[g]) stop_ok = 1'b0;
            end
            if (last_rst <= t0) begin
                n_cmp++;
                if (sb_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL frame_dut%0d: got unexpected frame %02h idx %0d, required no frame", g, d, idx_s);
                end else begin
                    e = sb_q.pop_front();
                    if (e.id != g || e.data != d || e.par != p || e.idx != idx_s || st || !stop_ok) begin
                        n_fail++;
                        $display("FAIL frame_dut%0d: got data %02h par %0b idx %0d start %0b stop_ok %0b, required dut%0d data %02h par %0b idx %0d start 0 stop_ok 1",
                                 g, d, p, idx_s, st, stop_ok, e.id, e.data, e.par, e.idx);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", name, got, exp);
        end
    endtask

    task automatic push(input int id, input logic [7:0] d, input logic p, input int idx);
        exp_t e;
        e.id = id; e.data = d; e.par = p; e.idx = idx;
        sb_q.push_back(e);
    endtask

    task automatic write_buf(input int g, input int a, input logic [7:0] d);
        @(negedge clk);
        wr_en_v[g] = 1'b1; wr_addr = 2'(a); wr_data = d;
        @(negedge clk);
        wr_en_v[g] = 1'b0;
    endtask

    task automatic send(input int g, input int len);
        @(negedge clk);
        msg_len = 3'(len); start_v[g] = 1'b1;
        @(negedge clk);
        start_v[g] = 1'b0;
    endtask

    task automatic wait_done(input int g, input int maxc);
        int c = 0;
        while (!done_v[g] && c < maxc) begin
            @(negedge clk);
            c++;
        end
        check($sformatf("done_dut%0d_within_%0d", g, maxc), int'(done_v[g]), 1);
    endtask

    task automatic wait_fall(input int g, input int maxc, output time t);
        logic prev;
        int   c = 0;
        logic found = 1'b0;
        prev = txd_v[g];
        t = 0;
        while (!found && c < maxc) begin
            @(negedge clk);
            c++;
            if (prev && !txd_v[g]) begin
                found = 1'b1;
                t = $time;
            end
            prev = txd_v[g];
        end
        if (!found) begin
            n_cmp++; n_fail++;
            $display("FAIL fall_dut%0d: got no start bit in %0d cycles, required one", g, maxc);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion, required finish before 500000");
        $fatal(1);
    end

    initial begin
        int  dc, seen, low, late;
        time t1, t2;
        for (int i = 0; i < 3; i++) begin
            wr_en_v[i] = 1'b0;
            start_v[i] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rst_busy%0d", i), int'(busy_v[i]), 0);
            check($sformatf("rst_done%0d", i), int'(done_v[i]), 0);
            check($sformatf("rst_txd%0d", i), int'(txd_v[i]), 1);
            check($sformatf("rst_idx%0d", i), int'(byte_idx_v[i]), 0);
        end
        reset_n = 1'b1;

        // four-byte message with start latency
        for (int i = 0; i < 4; i++) write_buf(0, i, msg_a[i]);
        for (int i = 0; i < 4; i++) push(0, msg_a[i], 1'b0, i);
        dc = done_cnt[0];
        @(negedge clk);
        msg_len = 3'd4; start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        check("t1_busy_k", int'(busy_v[0]), 1);
        check("t1_txd_k", int'(txd_v[0]), 1);
        @(negedge clk);
        check("t1_txd_k1", int'(txd_v[0]), 1);
        @(negedge clk);
        check("t1_txd_k2", int'(txd_v[0]), 0);
        wait_done(0, 600);
        repeat (3) @(negedge clk);
        check("t1_done_once", done_cnt[0] - dc, 1);
        check("t1_busy_end", int'(busy_v[0]), 0);
        check("t1_drained", sb_q.size(), 0);

        // even parity with two stop bits, then odd parity
        write_buf(1, 0, 8'h00);
        write_buf(1, 1, 8'h07);
        push(1, 8'h00, 1'b0, 0);
        push(1, 8'h07, 1'b1, 1);
        send(1, 2);
        wait_fall(1, 20, t1);
        wait_fall(1, 200, t2);
        check("t2_frame_period_clks", int'((t2 - t1) / 10), 121);
        wait_done(1, 400);
        repeat (3) @(negedge clk);
        check("t2_even_drained", sb_q.size(), 0);
        write_buf(2, 0, 8'h07);
        push(2, 8'h07, 1'b0, 0);
        send(2, 1);
        wait_done(2, 300);
        repeat (3) @(negedge clk);
        check("t2_odd_drained", sb_q.size(), 0);

        // zero-length message
        dc = done_cnt[0];
        seen = 0; low = 0; late = 0;
        @(negedge clk);
        msg_len = 3'd0; start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (done_v[0]) seen++;
            if (!txd_v[0]) low++;
            if (seen > 0 && busy_v[0] && !done_v[0]) late++;
            @(negedge clk);
        end
        check("t3_done_pulses", seen, 1);
        check("t3_txd_low_cycles", low, 0);
        check("t3_busy_after_done", late, 0);
        check("t3_done_count", done_cnt[0] - dc, 1);

        // msg_len beyond DEPTH clamps to DEPTH
        for (int i = 0; i < 4; i++) push(0, msg_a[i], 1'b0, i);
        dc = done_cnt[0];
        send(0, 7);
        wait_done(0, 600);
        repeat (3) @(negedge clk);
        check("t4_done_once", done_cnt[0] - dc, 1);
        check("t4_drained", sb_q.size(), 0);

        // start and write while busy are ignored
        for (int i = 0; i < 4; i++) push(0, msg_a[i], 1'b0, i);
        dc = done_cnt[0];
        send(0, 4);
        repeat (150) @(negedge clk);
        wr_en_v[0] = 1'b1; wr_addr = 2'd2; wr_data = 8'h5A; start_v[0] = 1'b1;
        @(negedge clk);
        wr_en_v[0] = 1'b0; start_v[0] = 1'b0;
        wait_done(0, 600);
        repeat (60) @(negedge clk);
        check("t5_done_once", done_cnt[0] - dc, 1);
        check("t5_busy_idle", int'(busy_v[0]), 0);
        check("t5_drained", sb_q.size(), 0);

        // reset during data bit 3 aborts; restart sends the whole retained buffer
        send(0, 4);
        wait_fall(0, 20, t1);
        repeat (45) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("t6_rst_txd", int'(txd_v[0]), 1);
        check("t6_rst_busy", int'(busy_v[0]), 0);
        check("t6_rst_idx", int'(byte_idx_v[0]), 0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (150) @(negedge clk);
        for (int i = 0; i < 4; i++) push(0, msg_a[i], 1'b0, i);
        dc = done_cnt[0];
        send(0, 4);
        wait_done(0, 600);
        repeat (3) @(negedge clk);
        check("t6_done_once", done_cnt[0] - dc, 1);
        check("t6_drained", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
